// File: rtl/data_mem_pkg.sv
// Shared definitions for the RV32I data-memory responder: funct3 codes, FSM states, size decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a.
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Access size in bytes (1/2/4); 0 marks an illegal funct3/direction pair.
    // Unsigned loads have no store counterpart, so they are illegal with we=1.
    function automatic logic [2:0] size_decode(input logic [2:0] funct3, input logic we);
        logic [2:0] size;
        case (funct3)
            F3_B:    size = 3'd1;
            F3_H:    size = 3'd2;
            F3_W:    size = 3'd4;
            F3_BU:   size = we ? 3'd0 : 3'd1;
            F3_HU:   size = we ? 3'd0 : 3'd2;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of little-endian assembled load bytes according to funct3.
// Latency: combinational.
// Backpressure: none; pure function of its inputs (shared with the core's load-wrap path).
module load_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    // Pick the extension for the access size; unknown codes return zero.
    always_comb begin
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    data = raw;
            F3_BU:   data = {24'd0, raw[7:0]};
            F3_HU:   data = {16'd0, raw[15:0]};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane-masked stores and extended loads on an internal word array.
// Latency: resp_valid one cycle after an aligned/illegal accept, two cycles for a split access.
// Backpressure: req_ready drops for the single SPLIT cycle of a misaligned access.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = AW + 2;

    state_t        state;
    state_t        state_nxt;

    // Request latched across the SPLIT cycle, plus the beat-1 word for split loads.
    logic [BW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_funct3;
    logic          lat_we;
    logic [31:0]   beat1_buf;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [BW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_funct3;
    logic          cur_we;
    logic [2:0]    cur_size;
    logic          cur_illegal;
    logic [1:0]    off;
    logic [AW-1:0] widx;
    logic [AW-1:0] widx_nxt;
    logic          is_split;
    logic [3:0]    size_mask;
    logic [7:0]    span_be;
    logic [63:0]   span_wdata;
    logic [63:0]   span_rdata;
    logic [31:0]   lo_word;
    logic [31:0]   ext_data;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          done;

    logic          unused_bits;
    assign unused_bits = ^{req_addr[31:BW], span_rdata[63:32]};

    // Operate on the live request in IDLE and on the latched one during SPLIT.
    always_comb begin
        if (state == SPLIT) begin
            cur_addr   = lat_addr;
            cur_wdata  = lat_wdata;
            cur_funct3 = lat_funct3;
            cur_we     = lat_we;
        end else begin
            cur_addr   = req_addr[BW-1:0];
            cur_wdata  = req_wdata;
            cur_funct3 = req_funct3;
            cur_we     = req_we;
        end
    end

    // Lane decode over an 8-byte window spanning word widx and widx+1 (wrapping silently).
    always_comb begin
        cur_size    = size_decode(cur_funct3, cur_we);
        cur_illegal = (cur_size == 3'd0);
        off         = cur_addr[1:0];
        widx        = cur_addr[BW-1:2];
        widx_nxt    = widx + AW'(1);
        is_split    = !cur_illegal && (({2'b00, off} + {1'b0, cur_size}) > 4'd4);
        case (cur_size)
            3'd1:    size_mask = 4'h1;
            3'd2:    size_mask = 4'h3;
            3'd4:    size_mask = 4'hF;
            default: size_mask = 4'h0;
        endcase
        span_be    = {4'h0, size_mask} << off;
        span_wdata = {32'd0, cur_wdata} << {off, 3'b000};
        lo_word    = (state == SPLIT) ? beat1_buf : mem[widx];
        span_rdata = {mem[widx_nxt], lo_word} >> {off, 3'b000};
    end

    load_extend u_load_extend (
        .raw    (span_rdata[31:0]),
        .funct3 (cur_funct3),
        .data   (ext_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a split access spends exactly one extra cycle in SPLIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && is_split) state_nxt = SPLIT;
            SPLIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake, write port selection and completion strobe.
    always_comb begin
        req_ready = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = widx;
        wr_be     = span_be[3:0];
        wr_data   = span_wdata[31:0];
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                wr_en     = req_valid && req_we && !cur_illegal;
                done      = req_valid && !is_split;
            end
            SPLIT: begin
                wr_en   = lat_we;
                wr_idx  = widx_nxt;
                wr_be   = span_be[7:4];
                wr_data = span_wdata[63:32];
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the request and the beat-1 word when a split access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            lat_we     <= 1'b0;
            beat1_buf  <= '0;
        end else if (state == IDLE && req_valid && is_split) begin
            lat_addr   <= req_addr[BW-1:0];
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            lat_we     <= req_we;
            beat1_buf  <= mem[widx];
        end
    end

    // Registered response; data and error hold until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= done;
            if (done) begin
                resp_err   <= cur_illegal;
                resp_rdata <= (cur_illegal || cur_we) ? 32'd0 : ext_data;
            end
        end
    end

    // Byte-lane-masked array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
// Latency: checks 1-cycle aligned and 2-cycle split responses, plus back-to-back streaming.
// Backpressure: observes req_ready during split accesses and after reset.
module tb_data_mem_responder;

    localparam int D  = 1024;
    localparam int NB = 4 * D;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int passed = 0;

    logic [7:0] ref_mem [NB];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        stall;
        logic        pulse_ok;
    } obs_t;

    data_mem_responder #(.DEPTH_WORDS(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Reference model: memory as a flat byte array, addresses wrap modulo its size.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, output logic [31:0] rd, output logic err,
                               output int lat);
        int size;
        int ba;
        logic [31:0] v;
        case (f3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            3'd4:    size = we ? 0 : 1;
            3'd5:    size = we ? 0 : 2;
            default: size = 0;
        endcase
        ba  = int'(addr & 32'(NB - 1));
        err = (size == 0);
        rd  = 32'd0;
        lat = (!err && ((ba % 4) + size > 4)) ? 2 : 1;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) ref_mem[(ba + k) % NB] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v = v | (32'(ref_mem[(ba + k) % NB]) << (8 * k));
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // Drive one request, wait for its response and record what the DUT did.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output obs_t got);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got.stall = !req_ready;
        got.lat   = 0;
        n = 1;
        while (got.lat == 0 && n <= 6) begin
            if (resp_valid) got.lat = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
        got.rd  = resp_rdata;
        got.err = resp_err;
        @(negedge clk);
        got.pulse_ok = !resp_valid;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output obs_t exp, output obs_t got);
        logic [31:0] rd;
        logic        err;
        int          lat;
        model_apply(we, addr, wdata, f3, rd, err, lat);
        exp.rd       = rd;
        exp.err      = err;
        exp.lat      = lat;
        exp.stall    = (lat == 2);
        exp.pulse_ok = 1'b1;
        run_req(we, addr, wdata, f3, got);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", resp_valid); else passed++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else passed++;
        checks++; if (resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", resp_err); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    endtask

    // Aligned word traffic every cycle; fill mode writes every word to seed the array.
    task automatic test_back_to_back(input int n, input bit fill);
        logic [31:0] exp_q [$];
        logic [31:0] e;
        logic [31:0] a;
        logic [31:0] wd;
        logic        er;
        logic        we;
        int          l;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++; if (resp_valid !== 1'b1) $display("FAIL b2b_valid beat %0d got %b want 1", i - 1, resp_valid); else passed++;
                checks++; if (resp_rdata !== e) $display("FAIL b2b_rdata beat %0d got %h want %h", i - 1, resp_rdata, e); else passed++;
            end
            if (i < n) begin
                a  = fill ? 32'(i * 4) : 32'($urandom_range(0, D - 1) * 4);
                we = fill ? 1'b1 : 1'($urandom_range(0, 1));
                wd = $urandom;
                model_apply(we, a, wd, 3'd2, e, er, l);
                exp_q.push_back(e);
                req_valid  = 1'b1;
                req_we     = we;
                req_addr   = a;
                req_wdata  = wd;
                req_funct3 = 3'd2;
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_tail_valid got %b want 0", resp_valid); else passed++;
    endtask

    task automatic test_word();
        obs_t e, g;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, e, g);
        checks++; if (g.lat !== 1) $display("FAIL sw_latency got %0d want 1", g.lat); else passed++;
        checks++; if (g.rd !== 32'd0 || g.err !== 1'b0) $display("FAIL sw_resp got %h/%b want 0/0", g.rd, g.err); else passed++;
        do_req(1'b0, 32'h10, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== 32'hDEAD_BEEF) $display("FAIL lw_data got %h want deadbeef", g.rd); else passed++;
        checks++; if (g.err !== 1'b0) $display("FAIL lw_err got %b want 0", g.err); else passed++;
        checks++; if (g.lat !== 1) $display("FAIL lw_latency got %0d want 1", g.lat); else passed++;
        checks++; if (g.pulse_ok !== 1'b1) $display("FAIL lw_pulse resp_valid stayed high"); else passed++;
    endtask

    task automatic test_byte();
        obs_t e, g;
        do_req(1'b1, 32'h13, 32'h0000_0080, 3'd0, e, g);
        do_req(1'b0, 32'h13, 32'h0, 3'd0, e, g);
        checks++; if (g.rd !== 32'hFFFF_FF80) $display("FAIL lb_sign got %h want ffffff80", g.rd); else passed++;
        do_req(1'b0, 32'h13, 32'h0, 3'd4, e, g);
        checks++; if (g.rd !== 32'h0000_0080) $display("FAIL lbu_zero got %h want 00000080", g.rd); else passed++;
        do_req(1'b0, 32'h10, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== 32'h80AD_BEEF) $display("FAIL sb_lanes got %h want 80adbeef", g.rd); else passed++;
    endtask

    task automatic test_split();
        obs_t e, g;
        do_req(1'b1, 32'h0E, 32'h1122_3344, 3'd2, e, g);
        checks++; if (g.stall !== 1'b1) $display("FAIL split_sw_ready got stall=%b want 1", g.stall); else passed++;
        checks++; if (g.lat !== 2) $display("FAIL split_sw_latency got %0d want 2", g.lat); else passed++;
        do_req(1'b0, 32'h0E, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== 32'h1122_3344) $display("FAIL split_lw got %h want 11223344", g.rd); else passed++;
        checks++; if (g.lat !== 2) $display("FAIL split_lw_latency got %0d want 2", g.lat); else passed++;
        do_req(1'b0, 32'h0F, 32'h0, 3'd5, e, g);
        checks++; if (g.rd !== 32'h0000_2233) $display("FAIL split_lhu got %h want 00002233", g.rd); else passed++;
        checks++; if (g.lat !== 2 || g.stall !== 1'b1) $display("FAIL split_lhu_timing got lat=%0d stall=%b want 2/1", g.lat, g.stall); else passed++;
    endtask

    task automatic test_wrap();
        obs_t e, g;
        do_req(1'b1, 32'(NB - 1), 32'h0000_A55A, 3'd1, e, g);
        checks++; if (g.lat !== 2) $display("FAIL wrap_sh_latency got %0d want 2", g.lat); else passed++;
        do_req(1'b0, 32'(NB - 1), 32'h0, 3'd1, e, g);
        checks++; if (g.rd !== 32'hFFFF_A55A) $display("FAIL wrap_lh got %h want ffffa55a", g.rd); else passed++;
        do_req(1'b0, 32'h0, 32'h0, 3'd4, e, g);
        checks++; if (g.rd !== 32'h0000_00A5) $display("FAIL wrap_byte0 got %h want 000000a5", g.rd); else passed++;
        do_req(1'b0, 32'hFFFF_FFFF, 32'h0, 3'd5, e, g);
        checks++; if (g.rd !== 32'h0000_A55A) $display("FAIL wrap_upper_bits got %h want 0000a55a", g.rd); else passed++;
    endtask

    task automatic test_illegal();
        obs_t e, g;
        obs_t base;
        logic [2:0] f3s [5];
        logic       wes [5];
        f3s = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        wes = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_req(1'b0, 32'h20, 32'h0, 3'd2, e, base);
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], 32'h20, 32'hFFFF_FFFF, f3s[i], e, g);
            checks++; if (g.err !== 1'b1) $display("FAIL illegal_err f3=%0d we=%b got %b want 1", f3s[i], wes[i], g.err); else passed++;
            checks++; if (g.rd !== 32'd0) $display("FAIL illegal_rdata f3=%0d got %h want 0", f3s[i], g.rd); else passed++;
            checks++; if (g.lat !== 1) $display("FAIL illegal_latency f3=%0d got %0d want 1", f3s[i], g.lat); else passed++;
        end
        do_req(1'b0, 32'h20, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== base.rd) $display("FAIL illegal_no_write got %h want %h", g.rd, base.rd); else passed++;
        checks++; if (g.rd !== e.rd) $display("FAIL illegal_model got %h want %h", g.rd, e.rd); else passed++;
    endtask

    task automatic test_reset_split();
        obs_t e, g;
        int   seen;
        do_req(1'b1, 32'h00, 32'h0102_0304, 3'd2, e, g);
        do_req(1'b1, 32'h04, 32'h5566_7788, 3'd2, e, g);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h02;
        req_wdata  = 32'hAABB_CCDD;
        req_funct3 = 3'd2;
        @(posedge clk);
        #2;
        rst       = 1'b1;
        req_valid = 1'b0;
        ref_mem[2] = 8'hDD;
        ref_mem[3] = 8'hCC;
        seen = 0;
        @(negedge clk);
        if (resp_valid) seen++;
        @(negedge clk);
        if (resp_valid) seen++;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_split_ready got %b want 1", req_ready); else passed++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_split_rdata got %h want 0", resp_rdata); else passed++;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_split_no_resp got %0d pulses want 0", seen); else passed++;
        do_req(1'b0, 32'h00, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== 32'hCCDD_0304) $display("FAIL rst_split_beat1 got %h want ccdd0304", g.rd); else passed++;
        do_req(1'b0, 32'h04, 32'h0, 3'd2, e, g);
        checks++; if (g.rd !== 32'h5566_7788) $display("FAIL rst_split_beat2_dropped got %h want 55667788", g.rd); else passed++;
    endtask

    task automatic test_random(input int n);
        obs_t e, g;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            do_req(we, a, wd, f3, e, g);
            checks++; if (g.rd !== e.rd) $display("FAIL rand_rdata #%0d we=%b f3=%0d a=%h got %h want %h", i, we, f3, a, g.rd, e.rd); else passed++;
            checks++; if (g.err !== e.err) $display("FAIL rand_err #%0d got %b want %b", i, g.err, e.err); else passed++;
            checks++; if (g.lat !== e.lat || g.stall !== e.stall) $display("FAIL rand_timing #%0d got lat=%0d stall=%b want %0d/%b", i, g.lat, g.stall, e.lat, e.stall); else passed++;
            checks++; if (g.pulse_ok !== 1'b1) $display("FAIL rand_pulse #%0d resp_valid wider than one cycle", i); else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        test_reset();
        test_back_to_back(D, 1'b1);
        test_word();
        test_byte();
        test_split();
        test_wrap();
        test_illegal();
        test_reset_split();
        test_back_to_back(64, 1'b0);
        test_random(300);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined RV32I core. It accepts load/store requests from the memory stage, performs byte-lane-masked stores into an internal word array, and returns sign- or zero-extended load data one cycle after completion. Misaligned accesses are split into two word beats by a small state machine that stalls the pipeline. It is the memory-side counterpart of the pipeline register that carries store data out of the core and wrapped load data back in.

## Interface
- DEPTH_WORDS, 1024: word count of the internal array; power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; only bits [log2(DEPTH_WORDS)+1:0] are used, and upper bits are ignored.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- req_funct3  in  3  RV32I size/sign code.
- req_ready  out  1  request accepted at this edge when req_valid=1.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3; valid with resp_valid.

## Operation
- funct3 codes:
  - 000 LB/SB; 001 LH/SH; 010 LW/SW; 100 LBU; 101 LHU.
  - 100/101 with req_we=1 are illegal.
  - 011, 110 and 111 are illegal.
  - An illegal request is accepted with no array write and produces resp_valid=1, resp_err=1, resp_rdata=0.
- Size is 1, 2 or 4 bytes; off = req_addr[1:0]; widx = req_addr[log2(DEPTH_WORDS)+1:2].
- Lane k (0..size-1) maps to byte position p = off+k. If p<4, it falls in word widx, lane p. If p>=4, it falls in word (widx+1) mod DEPTH_WORDS, lane p-4. Word index wrap-around is silent.
- An access is aligned when off+size <= 4; otherwise it is split.
- Stores write only the enabled byte lanes (little-endian); other bytes are unchanged.
- Loads assemble bytes little-endian, then extend:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- The array is read combinationally and written on the clock edge. A load accepted the cycle after a store sees the stored data.
- FSM states: IDLE, SPLIT.
  - IDLE with an aligned or illegal request accepted: perform the beat, stay in IDLE, raise resp_valid next cycle.
  - IDLE with a split request accepted: perform beat 1 (lanes in widx), latch the request and the beat-1 bytes, go to SPLIT.
  - SPLIT: perform beat 2 (lanes in widx+1), go to IDLE, raise resp_valid next cycle.
- req_ready = (state==IDLE). Requests presented in SPLIT are not sampled.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched request and byte buffer cleared. Array contents are not reset.
- Reset during SPLIT drops beat 2. Store bytes already written in beat 1 remain (partial store is accepted behaviour), and no resp_valid is produced.

## Timing
- Aligned or illegal request accepted at edge N: resp_valid is high for the cycle after edge N; the store is visible from edge N.
- Split request accepted at edge N: req_ready is low for cycle N..N+1; beat 2 occurs at edge N+1; resp_valid is high for the cycle after edge N+1.
- Throughput is one aligned request per cycle. Back-to-back requests produce back-to-back resp_valid pulses.
- resp_rdata and resp_err are registered and hold their value until the next resp_valid.

## Structure
- Package data_mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, SPLIT);
  - a size-decode function returning 1/2/4 or illegal.
- Sub-module load_extend: combinational; takes the assembled 32-bit little-endian bytes plus funct3 and outputs the extended word. This same block is reused for the core's load-wrap path.
- The top level contains the FSM, lane-enable generation, the array, and the beat-1 byte buffer.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10: resp_rdata=0xDEADBEEF one cycle after accept, resp_err=0.
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080. Bytes 0x10–0x12 unchanged (LW @0x10 → 0x80ADBEEF).
- Split SW 0x11223344 @0x0E: req_ready low one cycle. Then LW @0x0E → 0x11223344, LHU @0x0F → 0x00002233, with resp_valid delayed by 2 cycles for the split load.
- Wrap: SH 0xA55A @ byte 4*DEPTH_WORDS-1, then LH same address → 0xFFFFA55A; byte 0 of word 0 reads 0xA5.
- funct3=011 load and funct3=100 with req_we=1: resp_err=1, resp_rdata=0, memory unchanged.
- Assert rst during SPLIT of SW 0xAABBCCDD @0x02: bytes 0x02–0x03 equal DD/CC, bytes 0x04–0x05 unchanged, no resp_valid, req_ready=1 after reset.
